// File: rtl/sha256_if.sv
// Handshake, block and ROM-lookup signals between the SHA controller/K ROM and the round engine.
interface sha256_if;
  logic         start;
  logic         init;
  logic [511:0] blk;
  logic [5:0]   k_idx;
  logic [31:0]  k_in;
  logic         busy;
  logic         done;
  logic [255:0] digest;

  modport master (output start, init, blk, k_in, input k_idx, busy, done, digest);
  modport slave  (input start, init, blk, k_in, output k_idx, busy, done, digest);
endinterface

// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: one round per clock, round constant fetched from an external K ROM.
//   state | meaning
//   IDLE  | waiting for start; digest holds the last result
//   ROUND | applying round k_idx (0..63)
//   FINAL | folding a..h into H, done pulses next cycle
module sha256_round_engine #(
  parameter logic [255:0] H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
  input  logic     clk,
  input  logic     rst,
  sha256_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t       state_q, state_d;
  logic [5:0]   k_idx_q;
  logic         done_q;
  logic [255:0] h_q;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [31:0]  w [16];
  logic [31:0]  t1, t2, w_new;
  logic [255:0] cur;
  logic         busy_c;

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  always_comb begin
    t1    = h + bsig1(e) + ((e & f) ^ (~e & g)) + bus.k_in + w[0];
    t2    = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    // computed 16 rounds ahead of use, so the window always holds W[t..t+15]
    w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    cur   = {a, b, c, d, e, f, g, h};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    case (state_q)
      IDLE:    if (bus.start) state_d = ROUND;
      ROUND: begin
        busy_c = 1'b1;
        if (k_idx_q == 6'd63) state_d = FINAL;
      end
      FINAL: begin
        busy_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_idx_q <= '0;
      done_q  <= 1'b0;
      h_q     <= H_INIT;
      {a, b, c, d, e, f, g, h} <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          k_idx_q <= '0;
          if (bus.start) begin
            for (int i = 0; i < 16; i++) w[i] <= bus.blk[511 - 32*i -: 32];
            if (bus.init) begin
              h_q <= H_INIT;
              {a, b, c, d, e, f, g, h} <= H_INIT;
            end else begin
              {a, b, c, d, e, f, g, h} <= h_q;
            end
          end
        end
        ROUND: begin
          h <= g;
          g <= f;
          f <= e;
          e <= d + t1;
          d <= c;
          c <= b;
          b <= a;
          a <= t1 + t2;
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15]   <= w_new;
          k_idx_q <= k_idx_q + 6'd1;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) h_q[32*i +: 32] <= h_q[32*i +: 32] + cur[32*i +: 32];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.k_idx  = k_idx_q;
  assign bus.busy   = busy_c;
  assign bus.done   = done_q;
  assign bus.digest = h_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Self-checking bench for sha256_round_engine: known vectors plus random blocks against a reference model.
module tb_sha256_round_engine;

  localparam logic [255:0] H0 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_2A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B = {448'h0, 32'h00000000, 32'h000001c0};

  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [255:0] ref_h = H0;

  sha256_if bus ();

  sha256_round_engine dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  assign bus.k_in = K[bus.k_idx];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] y;
    y = {x, x} >> n;
    return y[31:0];
  endfunction

  // Plain FIPS 180-4 compression over a full 64-word schedule.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_blk(input logic [511:0] b, input logic ini, input bit chk_seq, input bit poke);
    int cyc, busy_n;
    bit seen;
    ref_h = compress(ini ? H0 : ref_h, b);
    bus.start = 1'b1;
    bus.blk   = b;
    bus.init  = ini;
    @(negedge clk);
    bus.start = 1'b0;
    bus.blk   = {16{$urandom}};
    bus.init  = 1'($urandom);
    cyc = 1; busy_n = 0; seen = 0;
    while (!seen && cyc < 200) begin
      if (bus.busy) begin
        if (chk_seq) chk("k_idx", 256'(bus.k_idx), (busy_n < 64) ? 256'(busy_n) : 256'd0);
        busy_n++;
      end
      if (bus.done) seen = 1;
      else begin
        bus.start = poke && bus.busy && (bus.k_idx == 6'd10 || bus.k_idx == 6'd40);
        if (bus.start) bus.blk = {16{$urandom}};
        @(negedge clk);
        cyc++;
      end
    end
    bus.start = 1'b0;
    chk("done_seen", 256'(seen), 256'd1);
    if (chk_seq) begin
      // cycle 1 is the one opened by the accepting edge; done lands 65 cycles after it
      chk("latency", 256'(cyc), 256'd66);
      chk("busy_len", 256'(busy_n), 256'd65);
      chk("k_idx_done", 256'(bus.k_idx), 256'd0);
    end
    chk("digest_model", bus.digest, ref_h);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.init  = 1'b0;
    bus.blk   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 256'(bus.busy), 256'd0);
    chk("rst_done", 256'(bus.done), 256'd0);
    chk("rst_kidx", 256'(bus.k_idx), 256'd0);
    chk("rst_digest", bus.digest, H0);
    rst = 1'b0;
    @(negedge clk);

    run_blk(BLK_ABC, 1'b1, 1'b1, 1'b0);
    chk("abc", bus.digest, D_ABC);
    @(negedge clk);
    chk("done_pulse", 256'(bus.done), 256'd0);
    chk("digest_held", bus.digest, D_ABC);

    run_blk(BLK_ABC, 1'b1, 1'b0, 1'b1);
    chk("abc_ignored_start", bus.digest, D_ABC);
    @(negedge clk);
    chk("no_queued_start", 256'(bus.busy), 256'd0);

    run_blk(BLK_EMPTY, 1'b1, 1'b0, 1'b0);
    chk("empty", bus.digest, D_EMPTY);

    run_blk(BLK_2A, 1'b1, 1'b0, 1'b0);
    run_blk(BLK_2B, 1'b0, 1'b1, 1'b0);
    chk("two_block", bus.digest, D_TWO);
    @(negedge clk);

    for (int n = 0; n < 6; n++) begin
      logic [511:0] rb;
      for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom;
      run_blk(rb, 1'($urandom_range(0, 2) == 0), 1'b0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // abort mid-block with reset
    bus.start = 1'b1; bus.blk = BLK_ABC; bus.init = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 100 && bus.k_idx != 6'd30; i++) @(negedge clk);
    chk("reach_round30", 256'(bus.k_idx), 256'd30);
    rst = 1'b1;
    #1;
    chk("abort_busy", 256'(bus.busy), 256'd0);
    chk("abort_done", 256'(bus.done), 256'd0);
    chk("abort_kidx", 256'(bus.k_idx), 256'd0);
    chk("abort_digest", bus.digest, H0);
    @(negedge clk);
    rst = 1'b0;
    ref_h = H0;
    @(negedge clk);
    run_blk(BLK_ABC, 1'b1, 1'b1, 1'b0);
    chk("abc_after_abort", bus.digest, D_ABC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
